// File: rtl/cg_pkg.sv
// ---------------------------------------------------------------------------
// cg_pkg : shared definitions for the coil firing sequencer.
//   - state_e        : sequencer states (IDLE, ON, GAP, COOLDOWN)
//   - CREG_*         : bit positions inside the I2C control register
//   - EF_*           : bit positions inside the error/status flag byte
//   - EF_M_*         : single-bit masks built from the EF_* positions
//   - flag_byte()    : merges a coil index into a fault code byte
// ---------------------------------------------------------------------------
package cg_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ON       = 2'd1,
      GAP      = 2'd2,
      COOLDOWN = 2'd3
   } state_e;

   localparam int CREG_ARM   = 0;
   localparam int CREG_FIRE  = 1;
   localparam int CREG_ABORT = 2;

   localparam int EF_TIMEOUT  = 0;
   localparam int EF_STUCK    = 1;
   localparam int EF_ABORT    = 2;
   localparam int EF_NOTARMED = 3;
   localparam int EF_IDX_LSB  = 4;
   localparam int EF_IDX_MSB  = 6;
   localparam int EF_DONE     = 7;

   localparam logic [7:0] EF_M_TIMEOUT  = 8'h01 << EF_TIMEOUT;
   localparam logic [7:0] EF_M_STUCK    = 8'h01 << EF_STUCK;
   localparam logic [7:0] EF_M_ABORT    = 8'h01 << EF_ABORT;
   localparam logic [7:0] EF_M_NOTARMED = 8'h01 << EF_NOTARMED;
   localparam logic [7:0] EF_M_DONE     = 8'h01 << EF_DONE;

   // Fault code with the offending coil index placed in the index field.
   function automatic logic [7:0] flag_byte(input logic [7:0] code, input logic [2:0] idx);
      logic [7:0] f;
      f = code;
      f[EF_IDX_MSB:EF_IDX_LSB] = idx;
      return f;
   endfunction

endpackage

// File: rtl/cg_gate_sync.sv
// ---------------------------------------------------------------------------
// cg_gate_sync : N-wide 2-FF synchroniser for the optical gates followed by a
// registered rising-edge detector. A gate first sampled high at edge n shows
// as gate_lvl after edge n+1 and as a one-cycle gate_rise after edge n+2.
//   clk       in  system clock
//   rst_n     in  synchronous active-low reset
//   gate      in  raw asynchronous gate sensors
//   gate_lvl  out synchronised gate level
//   gate_rise out registered rising-edge pulse of the synchronised level
// ---------------------------------------------------------------------------
module cg_gate_sync #(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] gate,
   output logic [N-1:0] gate_lvl,
   output logic [N-1:0] gate_rise
);

   logic [N-1:0] meta_r;
   logic [N-1:0] sync_r;
   logic [N-1:0] prev_r;
   logic [N-1:0] rise_r;

   // Synchroniser chain and edge detector.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_r <= {N{1'b0}};
         sync_r <= {N{1'b0}};
         prev_r <= {N{1'b0}};
         rise_r <= {N{1'b0}};
      end else begin
         meta_r <= gate;
         sync_r <= meta_r;
         prev_r <= sync_r;
         rise_r <= sync_r & ~prev_r;
      end
   end

   assign gate_lvl  = sync_r;
   assign gate_rise = rise_r;

endmodule

// File: rtl/cg_coil_seq.sv
// ---------------------------------------------------------------------------
// cg_coil_seq : coil firing sequencer behind the I2C slave core. Energises the
// coils one at a time, handing over on each optical gate, and reports a flag
// byte plus the transit time (in cycles) of the last successful shot.
//   I_clk    in  system clock
//   I_rst_n  in  synchronous active-low reset
//   I_creg   in  control register: [0] arm, [1] fire (rising edge), [2] abort
//   I_gate   in  optical gate sensors (asynchronous)
//   O_coil   out coil drive, registered, at most one bit high
//   O_eflg   out status/error flags
//   O_acc    out cycles of the last successful shot (saturating)
//   O_busy   out high while a shot or its cooldown is in progress
// ---------------------------------------------------------------------------
module cg_coil_seq
   import cg_pkg::*;
#(
   parameter int N_COILS       = 3,
   parameter int MAX_PULSE_CYC = 50000,
   parameter int COOLDOWN_CYC  = 100000
) (
   input  logic               I_clk,
   input  logic               I_rst_n,
   input  logic [7:0]         I_creg,
   input  logic [N_COILS-1:0] I_gate,
   output logic [N_COILS-1:0] O_coil,
   output logic [7:0]         O_eflg,
   output logic [23:0]        O_acc,
   output logic               O_busy
);

   localparam int PW = $clog2(MAX_PULSE_CYC + 32'sd1);
   localparam int CW = $clog2(COOLDOWN_CYC + 32'sd1);
   localparam logic [2:0]         K_LAST     = 3'(N_COILS - 32'sd1);
   localparam logic [N_COILS-1:0] COIL0      = N_COILS'(1'b1);
   localparam logic [PW-1:0]      PULSE_LAST = PW'(MAX_PULSE_CYC - 32'sd1);
   localparam logic [CW-1:0]      COOL_LAST  = CW'(COOLDOWN_CYC - 32'sd1);
   localparam logic [23:0]        ACC_MAX    = 24'hFF_FFFF;

   state_e             state_r, state_s;
   logic [2:0]         k_r, k_s;
   logic [PW-1:0]      pulse_r;
   logic [CW-1:0]      cd_r;
   logic [23:0]        acc_cnt_r;
   logic               fire_prev_r;
   logic [N_COILS-1:0] coil_r, coil_s;
   logic [7:0]         eflg_r, eflg_s;
   logic [23:0]        acc_r, acc_s;
   logic               busy_r, busy_s;

   logic [N_COILS-1:0] gate_lvl_s, gate_rise_s, k_oh_s;
   logic gate_k_rise_s, gate_k_lvl_s, fire_edge_s, arm_s, abort_s;
   logic coil_act_s, timeout_s, cool_done_s, last_s;
   logic unused_creg_s;

   cg_gate_sync #(.N(N_COILS)) u_gate_sync (
      .clk       (I_clk),
      .rst_n     (I_rst_n),
      .gate      (I_gate),
      .gate_lvl  (gate_lvl_s),
      .gate_rise (gate_rise_s)
   );

   assign k_oh_s        = COIL0 << k_r;
   assign gate_k_rise_s = |(gate_rise_s & k_oh_s);
   assign gate_k_lvl_s  = |(gate_lvl_s & k_oh_s);
   assign fire_edge_s   = I_creg[CREG_FIRE] & ~fire_prev_r;
   assign arm_s         = I_creg[CREG_ARM];
   assign abort_s       = I_creg[CREG_ABORT] | ~arm_s;
   // The pulse counter only runs once the coil is really driven, so the first
   // ON(0) cycle (coil still rising) does not eat into the pulse budget.
   assign coil_act_s    = |coil_r;
   assign timeout_s     = coil_act_s && (pulse_r == PULSE_LAST);
   assign cool_done_s   = (cd_r == COOL_LAST);
   assign last_s        = (k_r == K_LAST);
   assign unused_creg_s = ^I_creg[7:3];

   // State register.
   always_ff @(posedge I_clk) begin
      if (!I_rst_n) begin
         state_r <= IDLE;
         k_r     <= 3'd0;
      end else begin
         state_r <= state_s;
         k_r     <= k_s;
      end
   end

   // Next-state logic; abort outranks gate edges and timeout.
   always_comb begin
      state_s = state_r;
      k_s     = k_r;
      case (state_r)
         IDLE: begin
            if (fire_edge_s && arm_s) begin
               state_s = gate_lvl_s[0] ? COOLDOWN : ON;
               k_s     = 3'd0;
            end else begin
               state_s = IDLE;
            end
         end
         ON: begin
            if (abort_s) begin
               state_s = COOLDOWN;
            end else if (gate_k_rise_s) begin
               if (last_s) begin
                  state_s = COOLDOWN;
               end else begin
                  state_s = GAP;
                  k_s     = k_r + 3'd1;
               end
            end else if (timeout_s) begin
               state_s = COOLDOWN;
            end else begin
               state_s = ON;
            end
         end
         GAP: begin
            if (abort_s || gate_k_lvl_s) begin
               state_s = COOLDOWN;
            end else begin
               state_s = ON;
            end
         end
         COOLDOWN: begin
            if (cool_done_s) begin
               state_s = IDLE;
            end else begin
               state_s = COOLDOWN;
            end
         end
         default: begin
            state_s = IDLE;
            k_s     = 3'd0;
         end
      endcase
   end

   // Next values of the registered outputs.
   always_comb begin
      eflg_s = eflg_r;
      acc_s  = acc_r;
      busy_s = (state_s != IDLE);
      // Coil follows the next state, except on entry from IDLE where the
      // coil rises one edge after the fire edge is accepted.
      if (state_s == ON && state_r != IDLE) begin
         coil_s = COIL0 << k_s;
      end else begin
         coil_s = {N_COILS{1'b0}};
      end
      case (state_r)
         IDLE: begin
            if (fire_edge_s) begin
               if (!arm_s) begin
                  eflg_s = EF_M_NOTARMED;
               end else if (gate_lvl_s[0]) begin
                  eflg_s = EF_M_STUCK;
               end else begin
                  eflg_s = 8'h00;
               end
            end else begin
               eflg_s = eflg_r;
            end
         end
         ON: begin
            if (abort_s) begin
               eflg_s = flag_byte(EF_M_ABORT, k_r);
            end else if (gate_k_rise_s && last_s) begin
               eflg_s = EF_M_DONE;
               acc_s  = acc_cnt_r;
            end else if (gate_k_rise_s) begin
               eflg_s = eflg_r;
            end else if (timeout_s) begin
               eflg_s = flag_byte(EF_M_TIMEOUT, k_r);
            end else begin
               eflg_s = eflg_r;
            end
         end
         GAP: begin
            if (abort_s) begin
               eflg_s = flag_byte(EF_M_ABORT, k_r);
            end else if (gate_k_lvl_s) begin
               eflg_s = flag_byte(EF_M_STUCK, k_r);
            end else begin
               eflg_s = eflg_r;
            end
         end
         COOLDOWN: eflg_s = eflg_r;
         default:  eflg_s = eflg_r;
      endcase
   end

   // Output registers, fire-edge history and the shot counters.
   always_ff @(posedge I_clk) begin
      if (!I_rst_n) begin
         fire_prev_r <= 1'b0;
         coil_r      <= {N_COILS{1'b0}};
         eflg_r      <= 8'h00;
         acc_r       <= 24'h00_0000;
         busy_r      <= 1'b0;
         pulse_r     <= {PW{1'b0}};
         cd_r        <= {CW{1'b0}};
         acc_cnt_r   <= 24'h00_0000;
      end else begin
         fire_prev_r <= I_creg[CREG_FIRE];
         coil_r      <= coil_s;
         eflg_r      <= eflg_s;
         acc_r       <= acc_s;
         busy_r      <= busy_s;
         if (state_r != ON) begin
            pulse_r <= {PW{1'b0}};
         end else if (coil_act_s) begin
            pulse_r <= pulse_r + PW'(1'b1);
         end else begin
            pulse_r <= pulse_r;
         end
         if (state_r == COOLDOWN) begin
            cd_r <= cd_r + CW'(1'b1);
         end else begin
            cd_r <= {CW{1'b0}};
         end
         // Cleared while idle so every accepted shot starts from zero.
         if (state_r == IDLE) begin
            acc_cnt_r <= 24'h00_0000;
         end else if ((state_r == ON || state_r == GAP) && acc_cnt_r != ACC_MAX) begin
            acc_cnt_r <= acc_cnt_r + 24'h00_0001;
         end else begin
            acc_cnt_r <= acc_cnt_r;
         end
      end
   end

   assign O_coil = coil_r;
   assign O_eflg = eflg_r;
   assign O_acc  = acc_r;
   assign O_busy = busy_r;

endmodule

// File: tb/tb_cg_coil_seq.sv
// ---------------------------------------------------------------------------
// tb_cg_coil_seq : directed self-checking bench for cg_coil_seq with
// N_COILS=3, MAX_PULSE_CYC=20, COOLDOWN_CYC=10. Inputs change 1 time unit
// after a rising edge; outputs are read at the same point, i.e. they show the
// values loaded at the edge just passed.
// ---------------------------------------------------------------------------
module tb_cg_coil_seq;

   logic        clk;
   logic        rst_n;
   logic [7:0]  creg;
   logic [2:0]  gate;
   logic [2:0]  coil;
   logic [7:0]  eflg;
   logic [23:0] acc;
   logic        busy;

   int n_checks;
   int n_fail;

   logic [2:0] coil_tr [0:63];
   logic [7:0] eflg_tr [0:63];
   logic       busy_tr [0:63];

   cg_coil_seq #(
      .N_COILS       (3),
      .MAX_PULSE_CYC (20),
      .COOLDOWN_CYC  (10)
   ) dut (
      .I_clk   (clk),
      .I_rst_n (rst_n),
      .I_creg  (creg),
      .I_gate  (gate),
      .O_coil  (coil),
      .O_eflg  (eflg),
      .O_acc   (acc),
      .O_busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Fire edge sampled at edge t (index 0); gate[j] sampled high only at
   // edge t+gj; abort level from edge t+abort_at on. Records outputs after
   // edges t .. t+ncyc-1.
   task automatic shot_cycles(input int g0, input int g1, input int g2,
                              input int abort_at, input int ncyc);
      for (int i = 0; i < ncyc; i++) begin
         creg = (i == 0) ? 8'h03 : 8'h01;
         if (abort_at >= 0 && i >= abort_at) creg = 8'h05;
         gate = {(g2 == i), (g1 == i), (g0 == i)};
         @(posedge clk);
         #1;
         coil_tr[i] = coil;
         eflg_tr[i] = eflg;
         busy_tr[i] = busy;
      end
      gate = 3'b000;
      creg = 8'h01;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      creg  = 8'h00;
      gate  = 3'b000;
      step(3);
      n_checks++; if (coil !== 3'b000) begin n_fail++; $display("FAIL reset_coil: got %b expected 000", coil); end
      n_checks++; if (eflg !== 8'h00) begin n_fail++; $display("FAIL reset_eflg: got %h expected 00", eflg); end
      n_checks++; if (acc !== 24'h0) begin n_fail++; $display("FAIL reset_acc: got %h expected 000000", acc); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      rst_n = 1'b1;
      step(3);
      n_checks++; if (busy !== 1'b0 || coil !== 3'b000) begin n_fail++; $display("FAIL reset_idle: busy %b coil %b expected 0 000", busy, coil); end
   endtask

   task automatic test_nominal;
      logic [2:0] exp_c;
      creg = 8'h01;
      step(2);
      shot_cycles(6, 15, 26, -1, 32);
      for (int i = 0; i < 32; i++) begin
         if (i >= 1 && i <= 8)        exp_c = 3'b001;
         else if (i >= 10 && i <= 17) exp_c = 3'b010;
         else if (i >= 19 && i <= 28) exp_c = 3'b100;
         else                         exp_c = 3'b000;
         n_checks++;
         if (coil_tr[i] !== exp_c) begin n_fail++; $display("FAIL nominal_coil t+%0d: got %b expected %b", i, coil_tr[i], exp_c); end
      end
      n_checks++; if (acc !== 24'd28) begin n_fail++; $display("FAIL nominal_acc: got %0d expected 28", acc); end
      n_checks++; if (eflg !== 8'h80) begin n_fail++; $display("FAIL nominal_eflg: got %h expected 80", eflg); end
      n_checks++; if (eflg_tr[28] !== 8'h00) begin n_fail++; $display("FAIL nominal_eflg_mid: got %h expected 00", eflg_tr[28]); end
      n_checks++; if (busy_tr[0] !== 1'b1 || busy_tr[29] !== 1'b1) begin n_fail++; $display("FAIL nominal_busy: got %b %b expected 1 1", busy_tr[0], busy_tr[29]); end
      step(12);
   endtask

   task automatic test_timeout;
      int on1;
      on1 = 0;
      shot_cycles(6, -1, -1, -1, 42);
      for (int i = 0; i < 42; i++) if (coil_tr[i] === 3'b010) on1++;
      n_checks++; if (on1 != 20) begin n_fail++; $display("FAIL timeout_width: got %0d cycles expected 20", on1); end
      n_checks++; if (coil_tr[29] !== 3'b010 || coil_tr[30] !== 3'b000) begin n_fail++; $display("FAIL timeout_edge: got %b %b expected 010 000", coil_tr[29], coil_tr[30]); end
      n_checks++; if (eflg_tr[30] !== 8'h11) begin n_fail++; $display("FAIL timeout_eflg: got %h expected 11", eflg_tr[30]); end
      n_checks++; if (acc !== 24'd28) begin n_fail++; $display("FAIL timeout_acc: got %0d expected 28", acc); end
      n_checks++; if (busy_tr[39] !== 1'b1 || busy_tr[40] !== 1'b0) begin n_fail++; $display("FAIL timeout_cool: got %b %b expected 1 0", busy_tr[39], busy_tr[40]); end
      step(5);
   endtask

   task automatic test_not_armed;
      creg = 8'h00;
      step(2);
      creg = 8'h02;
      step(1);
      n_checks++; if (eflg !== 8'h08) begin n_fail++; $display("FAIL notarmed_eflg: got %h expected 08", eflg); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL notarmed_busy: got %b expected 0", busy); end
      step(3);
      n_checks++; if (coil !== 3'b000 || eflg !== 8'h08) begin n_fail++; $display("FAIL notarmed_hold: coil %b eflg %h expected 000 08", coil, eflg); end
      creg = 8'h00;
      step(2);
   endtask

   task automatic test_stuck;
      int driven;
      driven = 0;
      creg = 8'h01;
      gate = 3'b001;
      step(4);
      creg = 8'h03;
      step(1);
      creg = 8'h01;
      n_checks++; if (eflg !== 8'h02) begin n_fail++; $display("FAIL stuck_eflg: got %h expected 02", eflg); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stuck_busy: got %b expected 1", busy); end
      for (int i = 0; i < 11; i++) begin
         if (coil !== 3'b000) driven++;
         step(1);
      end
      n_checks++; if (driven != 0) begin n_fail++; $display("FAIL stuck_coil: got %0d driven cycles expected 0", driven); end
      gate = 3'b000;
      step(5);
   endtask

   task automatic test_abort;
      int bcnt;
      bcnt = 0;
      shot_cycles(6, 15, -1, 22, 34);
      n_checks++; if (coil_tr[21] !== 3'b100) begin n_fail++; $display("FAIL abort_pre: got %b expected 100", coil_tr[21]); end
      n_checks++; if (coil_tr[22] !== 3'b000) begin n_fail++; $display("FAIL abort_coil: got %b expected 000", coil_tr[22]); end
      n_checks++; if (eflg_tr[22] !== 8'h24) begin n_fail++; $display("FAIL abort_eflg: got %h expected 24", eflg_tr[22]); end
      for (int i = 22; i < 32; i++) if (busy_tr[i] === 1'b1) bcnt++;
      n_checks++; if (bcnt != 10 || busy_tr[32] !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %0d cycles then %b expected 10 then 0", bcnt, busy_tr[32]); end
      step(3);
   endtask

   task automatic test_cooldown;
      creg = 8'h01;
      step(2);
      shot_cycles(6, 15, 26, -1, 30);
      n_checks++; if (eflg !== 8'h80) begin n_fail++; $display("FAIL cool_shot_eflg: got %h expected 80", eflg); end
      step(4);
      creg = 8'h03;
      step(1);
      creg = 8'h01;
      n_checks++; if (eflg !== 8'h80 || coil !== 3'b000) begin n_fail++; $display("FAIL cool_ignored: eflg %h coil %b expected 80 000", eflg, coil); end
      step(6);
      creg = 8'h03;
      step(1);
      creg = 8'h01;
      n_checks++; if (eflg !== 8'h00 || busy !== 1'b1) begin n_fail++; $display("FAIL cool_restart: eflg %h busy %b expected 00 1", eflg, busy); end
      step(1);
      n_checks++; if (coil !== 3'b001) begin n_fail++; $display("FAIL cool_restart_coil: got %b expected 001", coil); end
      creg = 8'h00;
      step(1);
      n_checks++; if (coil !== 3'b000 || eflg !== 8'h04) begin n_fail++; $display("FAIL cool_disarm: coil %b eflg %h expected 000 04", coil, eflg); end
      step(15);
      creg = 8'h01;
      step(2);
   endtask

   task automatic test_reset_mid_shot;
      shot_cycles(6, 15, 26, -1, 12);
      n_checks++; if (coil_tr[11] !== 3'b010) begin n_fail++; $display("FAIL rstmid_pre: got %b expected 010", coil_tr[11]); end
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      n_checks++; if (coil !== 3'b000 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_coil_busy: coil %b busy %b expected 000 0", coil, busy); end
      n_checks++; if (acc !== 24'h0 || eflg !== 8'h00) begin n_fail++; $display("FAIL rstmid_acc_eflg: acc %h eflg %h expected 000000 00", acc, eflg); end
      step(2);
      shot_cycles(6, 15, 26, -1, 30);
      n_checks++; if (coil_tr[1] !== 3'b001 || coil_tr[28] !== 3'b100 || coil_tr[29] !== 3'b000) begin n_fail++; $display("FAIL rstmid_reshot_coil: got %b %b %b expected 001 100 000", coil_tr[1], coil_tr[28], coil_tr[29]); end
      n_checks++; if (acc !== 24'd28 || eflg !== 8'h80) begin n_fail++; $display("FAIL rstmid_reshot: acc %0d eflg %h expected 28 80", acc, eflg); end
      step(12);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      creg     = 8'h00;
      gate     = 3'b000;
      test_reset();
      test_nominal();
      test_timeout();
      test_not_armed();
      test_stuck();
      test_abort();
      test_cooldown();
      test_reset_mid_shot();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
